// File: rtl/tile_feeder.sv
// tile_feeder: row buffer that loads a tile of up to DEPTH rows through a
// valid/ready write port, then streams it gap-free, one row per cycle, into
// the systolic input skew stage.
//
// Optional feature macro: TILE_FEEDER_REPLAY_EN
//   When defined, adds replay_i. This restreams the last completed tile
//   without reloading it.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start_i        begin a tile load (sampled only in IDLE)
//   len_i          rows in tile, clamped to DEPTH; 0 is ignored
//   wr_valid_i     write row valid
//   wr_ready_o     write row ready (high only in LOAD)
//   wr_data_i      write row, DATA_NUM elements
//   replay_i       restream stored tile (TILE_FEEDER_REPLAY_EN only)
//   data_o         streamed row, zero when input_valid_o is low
//   input_valid_o  row valid to skew stage
//   calc_done_o    marks last streamed row
//   busy_o         high in LOAD and STREAM
//   done_o         one-cycle pulse on the first IDLE cycle after streaming
module tile_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_NUM   = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i [0:DATA_NUM-1],
`ifdef TILE_FEEDER_REPLAY_EN
  input  logic                  replay_i,
`endif
  output logic [DATA_WIDTH-1:0] data_o [0:DATA_NUM-1],
  output logic                  input_valid_o,
  output logic                  calc_done_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                state;
  logic [LEN_W-1:0]      eff_len;
  logic [LEN_W-1:0]      wr_cnt;
  logic [LEN_W-1:0]      rd_cnt;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1][0:DATA_NUM-1];
`ifdef TILE_FEEDER_REPLAY_EN
  logic                  tile_valid;
`endif

  logic                  wr_fire;
  logic                  wr_last;
  logic                  rd_last;
  logic [LEN_W-1:0]      rd_next;
  logic [LEN_W-1:0]      len_clamped;

  assign wr_fire     = wr_valid_i & wr_ready_o;
  assign wr_last     = (wr_cnt == eff_len - LEN_W'(1));
  assign rd_last     = (rd_cnt == eff_len - LEN_W'(1));
  assign rd_next     = rd_cnt + LEN_W'(1);
  assign len_clamped = (len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_i;

  // Row storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[IDX_W'(wr_cnt)] <= wr_data_i;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      eff_len       <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      wr_ready_o    <= 1'b0;
      input_valid_o <= 1'b0;
      calc_done_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      data_o        <= '{default: '0};
`ifdef TILE_FEEDER_REPLAY_EN
      tile_valid    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && (len_i != '0)) begin
            eff_len    <= len_clamped;
            wr_cnt     <= '0;
            wr_ready_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= LOAD;
          end
`ifdef TILE_FEEDER_REPLAY_EN
          else if (!start_i && replay_i && tile_valid) begin
            rd_cnt        <= '0;
            data_o        <= mem[0];
            input_valid_o <= 1'b1;
            calc_done_o   <= (eff_len == LEN_W'(1));
            busy_o        <= 1'b1;
            state         <= STREAM;
          end
`endif
        end
        LOAD: begin
          if (wr_fire) begin
            wr_cnt <= wr_cnt + LEN_W'(1);
            if (wr_last) begin
              wr_ready_o    <= 1'b0;
              rd_cnt        <= '0;
              input_valid_o <= 1'b1;
              calc_done_o   <= (eff_len == LEN_W'(1));
              state         <= STREAM;
`ifdef TILE_FEEDER_REPLAY_EN
              tile_valid    <= 1'b1;
`endif
              // A one-row tile is being written on this very edge, so bypass.
              if (eff_len == LEN_W'(1)) data_o <= wr_data_i;
              else                      data_o <= mem[0];
            end
          end
        end
        STREAM: begin
          if (rd_last) begin
            input_valid_o <= 1'b0;
            calc_done_o   <= 1'b0;
            data_o        <= '{default: '0};
            busy_o        <= 1'b0;
            done_o        <= 1'b1;
            state         <= IDLE;
          end else begin
            rd_cnt      <= rd_next;
            data_o      <= mem[IDX_W'(rd_next)];
            calc_done_o <= (rd_next == eff_len - LEN_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
